tristate_bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a shared N-bit tristate bus made of one tristate_buffer per requester.
- Drives the per-buffer enables so that at most one buffer drives the bus at any time.
- Inserts a fixed turnaround gap (all enables low) between owners and caps each ownership at MAX_BURST cycles.
- Sits between requesting blocks and the bus buffers; the data path stays outside this block.

---
 rtl/tristate_bus_arbiter_if.sv | 16 +
 rtl/tristate_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/tristate_bus_arbiter_if.sv
// Request/ownership signals shared between the bus arbiter and its requesters.
// master: arbiter side; slave: requester side.
interface tristate_bus_arbiter_if #(
  parameter int unsigned NREQ = 4
) ();
  localparam int unsigned OW = $clog2(NREQ);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] en;
  logic [OW-1:0]   owner;
  logic            bus_busy;

  modport master (input req, output grant, output en, output owner, output bus_busy);
  modport slave  (output req, input grant, input en, input owner, input bus_busy);
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencer for a shared tristate bus: one-hot enables,
// capped burst length and a fixed all-off turnaround gap between owners.
module tristate_bus_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  tristate_bus_arbiter_if.master bus
);
  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned TW = $clog2(TURNAROUND + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [TW-1:0]   turn_q, turn_d;

  logic            any_req_c;
  logic            release_c;
  logic            turn_done_c;
  logic [OW-1:0]   win_c;

  // First requester at or after p, wrapping modulo NREQ.
  function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [OW-1:0] p);
    logic [OW-1:0] w;
    logic          found;
    int unsigned   idx;
    w     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(p) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && r[OW'(idx)]) begin
        found = 1'b1;
        w     = OW'(idx);
      end
    end
    return w;
  endfunction

  assign any_req_c   = |bus.req;
  assign release_c   = !bus.req[owner_q] || (burst_q == BW'(MAX_BURST));
  assign turn_done_c = (turn_q == TW'(TURNAROUND));
  assign win_c       = rr_pick(bus.req, ptr_q);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      turn_q  <= turn_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req_c) state_d = DRIVE;
      DRIVE:   if (release_c) state_d = TURN;
      TURN:    if (turn_done_c) state_d = any_req_c ? DRIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, pointer and counter updates; non-owner requests are only looked at when arbitrating.
  always_comb begin
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    turn_d  = turn_q;
    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          grant_d = NREQ'(1) << win_c;
          owner_d = win_c;
          burst_d = BW'(1);
        end
      end
      DRIVE: begin
        if (release_c) begin
          grant_d = '0;
          ptr_d   = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);
          turn_d  = TW'(1);
        end else begin
          burst_d = burst_q + BW'(1);
        end
      end
      TURN: begin
        if (!turn_done_c) begin
          turn_d = turn_q + TW'(1);
        end else begin
          turn_d = '0;
          if (any_req_c) begin
            grant_d = NREQ'(1) << win_c;
            owner_d = win_c;
            burst_d = BW'(1);
          end
        end
      end
      default: begin
        grant_d = '0;
      end
    endcase
  end

  assign bus.grant    = grant_q;
  assign bus.en       = grant_q;
  assign bus.owner    = owner_q;
  assign bus.bus_busy = (state_q != IDLE);
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench for tristate_bus_arbiter: directed scenarios plus random
// requests, checked against an ownership-level reference model.
module tb_tristate_bus_arbiter;
  localparam int unsigned NREQ       = 4;
  localparam int unsigned TURNAROUND = 1;
  localparam int unsigned MAX_BURST  = 4;
  localparam int unsigned STARVE_MAX = (NREQ - 1) * (MAX_BURST + TURNAROUND) + TURNAROUND;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tristate_bus_arbiter_if #(.NREQ(NREQ)) bus_if ();

  tristate_bus_arbiter #(
    .NREQ(NREQ), .TURNAROUND(TURNAROUND), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.master)
  );

  typedef struct {
    logic [NREQ-1:0] grant;
    int              owner;
    bit              busy;
    int              tag;
    bit              log;
  } exp_t;

  exp_t            sb[$];
  logic [NREQ-1:0] seq_log[$];
  logic [NREQ-1:0] exp_seq[24];
  int              errors   = 0;
  int              checks   = 0;
  int              edge_cnt = 0;
  bit              mon_en   = 1'b0;
  logic [NREQ-1:0] prev_en;
  int              wait_cnt[NREQ];

  // Reference model: who owns the bus, for how long, and the gap left before the next grant.
  int m_own, m_held, m_gap, m_ptr;
  bit m_turn;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_own = -1; m_held = 0; m_gap = 0; m_ptr = 0; m_turn = 1'b0;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < int'(NREQ); k++) begin
      int idx;
      idx = (m_ptr + k) % int'(NREQ);
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void model_edge(input logic [NREQ-1:0] r, input bit lg);
    exp_t e;
    int   w;
    if (m_own >= 0) begin
      if (!r[m_own] || m_held == int'(MAX_BURST)) begin
        m_ptr  = (m_own + 1) % int'(NREQ);
        m_own  = -1;
        m_turn = 1'b1;
        m_gap  = int'(TURNAROUND) - 1;
      end else begin
        m_held++;
      end
    end else if (m_turn && m_gap > 0) begin
      m_gap--;
    end else begin
      w      = pick(r);
      m_turn = 1'b0;
      if (w >= 0) begin
        m_own  = w;
        m_held = 1;
      end
    end
    e.grant = (m_own >= 0) ? NREQ'(1) << m_own : '0;
    e.owner = m_own;
    e.busy  = (m_own >= 0) || m_turn;
    e.tag   = edge_cnt + 1;
    e.log   = lg;
    sb.push_back(e);
  endfunction

  task automatic drive(input logic [NREQ-1:0] r, input bit lg);
    bus_if.req = r;
    model_edge(r, lg);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: invariants every cycle, scoreboard pop once the tagged edge has happened.
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_en = '0;
      for (int i = 0; i < int'(NREQ); i++) wait_cnt[i] = 0;
    end else begin
      check("en_eq_grant", bus_if.en, bus_if.grant);
      check("en_onehot", $countones(bus_if.en) <= 1, 1);
      check("gap_between_owners",
            (bus_if.en != '0) && (prev_en != '0) && (bus_if.en != prev_en), 0);
      prev_en = bus_if.en;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (bus_if.grant[i]) begin
          if (wait_cnt[i] != 0) check("starvation", wait_cnt[i] > int'(STARVE_MAX), 0);
          wait_cnt[i] = 0;
        end else if (bus_if.req[i]) begin
          wait_cnt[i]++;
        end else begin
          wait_cnt[i] = 0;
        end
      end
      if (sb.size() != 0 && sb[0].tag <= edge_cnt) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_tag", e.tag, edge_cnt);
        check("sb_grant", bus_if.grant, e.grant);
        check("sb_busy", bus_if.bus_busy, e.busy);
        if (e.owner >= 0) check("sb_owner", bus_if.owner, e.owner);
        if (e.log) seq_log.push_back(bus_if.en);
      end
    end
  end

  initial begin
    logic [NREQ-1:0] r;
    exp_seq = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0,
                4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0,
                4'h1, 4'h1, 4'h1, 4'h1};
    bus_if.req = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", bus_if.grant, 0);
    check("rst_en", bus_if.en, 0);
    check("rst_busy", bus_if.bus_busy, 0);
    check("rst_owner", bus_if.owner, 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Full contention from reset: strict rotation starting at index 0.
    for (int i = 0; i < 24; i++) drive('1, 1'b1);
    repeat (3) drive('0, 1'b0);
    check("contention_len", seq_log.size(), 24);
    for (int i = 0; i < 24 && i < seq_log.size(); i++) check("contention_seq", seq_log[i], exp_seq[i]);

    // Single short request.
    repeat (3) drive(4'b0010, 1'b0);
    repeat (4) drive('0, 1'b0);

    // Lone requester hitting the burst cap.
    repeat (12) drive(4'b1000, 1'b0);
    repeat (3) drive('0, 1'b0);

    // Handoff must wrap from pointer 3 to index 0.
    drive(4'b0100, 1'b0);
    drive(4'b0111, 1'b0);
    drive(4'b0011, 1'b0);
    drive(4'b0011, 1'b0);
    check("handoff_wrap", bus_if.grant, 4'b0001);
    repeat (3) drive(4'b0011, 1'b0);
    repeat (6) drive('0, 1'b0);

    // Asynchronous reset while a requester owns the bus.
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b0);
    check("pre_rst_grant", bus_if.grant, 4'b0100);
    mon_en = 1'b0;
    sb.delete();
    bus_if.req = '1;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_en", bus_if.en, 0);
    check("async_rst_grant", bus_if.grant, 0);
    check("async_rst_busy", bus_if.bus_busy, 0);
    check("async_rst_owner", bus_if.owner, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;
    drive('1, 1'b0);
    check("first_grant_after_rst", bus_if.grant, 4'b0001);
    repeat (4) drive('1, 1'b0);
    repeat (3) drive('0, 1'b0);

    // Random requests with some persistence so bursts and caps occur.
    r = '0;
    for (int n = 0; n < 10000; n++) begin
      for (int b = 0; b < int'(NREQ); b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      drive(r, 1'b0);
    end
    repeat (8) drive('0, 1'b0);
    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
